guess_entry: RTL and testbench

- Producer side of the three-digit number interface that the game display controller consumes: iNum1/iNum2/iNum3 plus a one-cycle iNumRdy strobe.
- Takes decoded key events from the keypad front end and assembles three decimal digits, with backspace, clear and enter.
- Rejects repeated digits and issues exactly one ready strobe per accepted entry.
- The first accepted entry is the secret answer; every later entry is a guess. The block tracks this phase and counts the guesses.

---
 rtl/guess_entry.sv | 151 +++++++++++++++
 tb/tb_guess_entry.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Keypad entry assembler: builds a three-digit entry with backspace/clear/enter,
// issues one ready strobe per accepted entry and tracks answer/guess phase.
module guess_entry #(
    parameter bit          ALLOW_REPEAT = 1'b0,
    parameter int unsigned MAX_GUESS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] oNum1,
    output logic [3:0] oNum2,
    output logic [3:0] oNum3,
    output logic       oNumRdy,
    output logic [3:0] ent_d1,
    output logic [3:0] ent_d2,
    output logic [3:0] ent_d3,
    output logic [1:0] ent_cnt,
    output logic       answer_set,
    output logic [3:0] guess_cnt,
    output logic       err_pulse
);

    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] KEY_BS    = 4'hA;
    localparam logic [DW-1:0] KEY_ENTER = 4'hB;
    localparam logic [DW-1:0] KEY_CLEAR = 4'hC;
    localparam logic [DW-1:0] EMPTY_POS = 4'hF;
    localparam logic [DW-1:0] GUESS_MAX = DW'(MAX_GUESS);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_ONE,
        S_TWO,
        S_FULL,
        S_SEND
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] d1_d, d2_d, d3_d;
    logic [DW-1:0] num1_d, num2_d, num3_d;
    logic          rdy_d, err_d, ans_d;
    logic [DW-1:0] gc_d;
    logic [1:0]    cnt_d;
    logic          is_dup, max_hit;

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            ent_d1     <= EMPTY_POS;
            ent_d2     <= EMPTY_POS;
            ent_d3     <= EMPTY_POS;
            ent_cnt    <= 2'd0;
            oNum1      <= '0;
            oNum2      <= '0;
            oNum3      <= '0;
            oNumRdy    <= 1'b0;
            answer_set <= 1'b0;
            guess_cnt  <= '0;
            err_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ent_d1     <= d1_d;
            ent_d2     <= d2_d;
            ent_d3     <= d3_d;
            ent_cnt    <= cnt_d;
            oNum1      <= num1_d;
            oNum2      <= num2_d;
            oNum3      <= num3_d;
            oNumRdy    <= rdy_d;
            answer_set <= ans_d;
            guess_cnt  <= gc_d;
            err_pulse  <= err_d;
        end
    end

    // Unfilled positions hold 0xF, which never matches a digit, so all three can be compared.
    assign is_dup  = !ALLOW_REPEAT &&
                     ((key_code == ent_d1) || (key_code == ent_d2) || (key_code == ent_d3));
    assign max_hit = answer_set && (guess_cnt == GUESS_MAX);

    always_comb begin
        state_d = state_q;
        d1_d    = ent_d1;
        d2_d    = ent_d2;
        d3_d    = ent_d3;
        num1_d  = oNum1;
        num2_d  = oNum2;
        num3_d  = oNum3;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        ans_d   = answer_set;
        gc_d    = guess_cnt;

        if (state_q == S_SEND) begin
            // Keys arriving here are dropped without error.
            num1_d  = ent_d1;
            num2_d  = ent_d2;
            num3_d  = ent_d3;
            rdy_d   = 1'b1;
            if (!answer_set) begin
                ans_d = 1'b1;
            end else if (guess_cnt < GUESS_MAX) begin
                gc_d = DW'(guess_cnt + 4'd1);
            end
            d1_d    = EMPTY_POS;
            d2_d    = EMPTY_POS;
            d3_d    = EMPTY_POS;
            state_d = S_EMPTY;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (state_q == S_FULL || is_dup) begin
                    err_d = 1'b1;
                end else begin
                    case (state_q)
                        S_EMPTY: begin d1_d = key_code; state_d = S_ONE;  end
                        S_ONE:   begin d2_d = key_code; state_d = S_TWO;  end
                        default: begin d3_d = key_code; state_d = S_FULL; end
                    endcase
                end
            end else if (key_code == KEY_BS) begin
                case (state_q)
                    S_ONE:   begin d1_d = EMPTY_POS; state_d = S_EMPTY; end
                    S_TWO:   begin d2_d = EMPTY_POS; state_d = S_ONE;   end
                    S_FULL:  begin d3_d = EMPTY_POS; state_d = S_TWO;   end
                    default: err_d = 1'b1;
                endcase
            end else if (key_code == KEY_ENTER) begin
                if (state_q == S_FULL && !max_hit) begin
                    state_d = S_SEND;
                end else begin
                    err_d = 1'b1;
                end
            end else if (key_code == KEY_CLEAR) begin
                d1_d    = EMPTY_POS;
                d2_d    = EMPTY_POS;
                d3_d    = EMPTY_POS;
                state_d = S_EMPTY;
            end
        end

        case (state_d)
            S_EMPTY: cnt_d = 2'd0;
            S_ONE:   cnt_d = 2'd1;
            S_TWO:   cnt_d = 2'd2;
            default: cnt_d = 2'd3;
        endcase
    end

endmodule

// File: tb/tb_guess_entry.sv
// Randomised and directed bench for guess_entry against a queue-based entry model.
module tb_guess_entry;

    localparam bit          ALLOW_REPEAT = 1'b0;
    localparam int unsigned MAX_GUESS    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] oNum1, oNum2, oNum3;
    logic       oNumRdy;
    logic [3:0] ent_d1, ent_d2, ent_d3;
    logic [1:0] ent_cnt;
    logic       answer_set;
    logic [3:0] guess_cnt;
    logic       err_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: typed digits, a pending send, phase and last issued number.
    int q[$];
    bit m_send, m_ans, m_rdy, m_err;
    int m_gc;
    int m_num[3];

    guess_entry #(.ALLOW_REPEAT(ALLOW_REPEAT), .MAX_GUESS(MAX_GUESS)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .oNum1(oNum1), .oNum2(oNum2), .oNum3(oNum3), .oNumRdy(oNumRdy),
        .ent_d1(ent_d1), .ent_d2(ent_d2), .ent_d3(ent_d3), .ent_cnt(ent_cnt),
        .answer_set(answer_set), .guess_cnt(guess_cnt), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pos(input int i);
        return (i < q.size()) ? q[i] : 15;
    endfunction

    function automatic bit held(input int d);
        foreach (q[i]) if (q[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_send = 0; m_ans = 0; m_rdy = 0; m_err = 0; m_gc = 0;
        m_num = '{0, 0, 0};
    endtask

    // One clock edge of the entry rules.
    task automatic model_step(input bit v, input int c);
        m_rdy = 0;
        m_err = 0;
        if (m_send) begin
            for (int i = 0; i < 3; i++) m_num[i] = pos(i);
            m_rdy = 1;
            if (!m_ans) m_ans = 1;
            else if (m_gc < int'(MAX_GUESS)) m_gc++;
            q.delete();
            m_send = 0;
        end else if (v) begin
            if (c <= 9) begin
                if (q.size() == 3 || (!ALLOW_REPEAT && held(c))) m_err = 1;
                else q.push_back(c);
            end else if (c == 10) begin
                if (q.size() == 0) m_err = 1;
                else void'(q.pop_back());
            end else if (c == 11) begin
                if (q.size() == 3 && !(m_ans && m_gc == int'(MAX_GUESS))) m_send = 1;
                else m_err = 1;
            end else if (c == 12) begin
                q.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("ent_d1", int'(ent_d1), pos(0));
        check("ent_d2", int'(ent_d2), pos(1));
        check("ent_d3", int'(ent_d3), pos(2));
        check("ent_cnt", int'(ent_cnt), q.size());
        check("oNumRdy", int'(oNumRdy), int'(m_rdy));
        check("oNum1", int'(oNum1), m_num[0]);
        check("oNum2", int'(oNum2), m_num[1]);
        check("oNum3", int'(oNum3), m_num[2]);
        check("answer_set", int'(answer_set), int'(m_ans));
        check("guess_cnt", int'(guess_cnt), m_gc);
        check("err_pulse", int'(err_pulse), int'(m_err));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input bit v, input int c);
        key_valid = v;
        key_code  = 4'(c);
        model_step(v, c);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        compare_all();
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) tick(1'b1, seq[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int r, c;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #2;
        model_reset();
        do_reset();

        // Answer 4,7,2 then one idle cycle to let SEND drain.
        keys('{4, 7, 2});
        check("echo_472", {28'd0, ent_d1, ent_d2, ent_d3}, 'h472);
        keys('{11});
        tick(1'b0, 0);
        check("answer_rdy", int'(oNumRdy), 1);
        tick(1'b0, 0);

        // Repeated digit, backspace, guess 5,8,9.
        keys('{1, 1});
        check("dup_err", int'(err_pulse), 1);
        keys('{12, 5, 6, 10, 8, 9, 11});
        tick(1'b0, 0);
        check("guess1_num", {28'd0, oNum1, oNum2, oNum3}, 'h589);

        // Partial enter rejected, then clear; reserved codes ignored.
        keys('{3, 11, 12, 13, 14, 15, 10});

        // Reset while in SEND: entry lost, phase back to start.
        keys('{1, 2, 3, 11});
        do_reset();
        check("rst_send_rdy", int'(oNumRdy), 0);

        // Answer plus MAX_GUESS guesses, then one refused enter.
        for (int g = 0; g <= int'(MAX_GUESS); g++) begin
            keys('{g, g + 1, g + 2, 11});
            tick(1'b0, 0);
        end
        keys('{7, 8, 9, 11});
        check("max_stay_full", int'(ent_cnt), 3);
        keys('{11, 12});

        // Random key streams with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 55)      c = int'($urandom_range(0, 9));
                else if (r < 72) c = 11;
                else if (r < 84) c = 10;
                else if (r < 90) c = 12;
                else             c = int'($urandom_range(0, 15));
                tick($urandom_range(0, 3) != 0, c);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
